// File: rtl/fp_add_pkg.sv
// fp_add_pkg: shared FP adder widths and operand/aligned-result bundles.
package fp_add_pkg;
  localparam int FP_MANT_W = 4;
  localparam int FP_EXP_W = 4;
  localparam int GRS_W = 2;
  typedef struct packed {
    logic sign;
    logic [FP_EXP_W-1:0] exp;
    logic [FP_MANT_W-1:0] mant;
  } fp_operand_t;
  typedef struct packed {
    logic big_sign;
    logic small_sign;
    logic [FP_EXP_W-1:0] big_exp;
    logic [FP_MANT_W+GRS_W-1:0] big_mant;
    logic [FP_MANT_W+GRS_W-1:0] small_mant;
    logic sticky;
    logic swapped;
  } fp_aligned_t;
endpackage

// File: rtl/fp_align_pipe_if.sv
// fp_align_pipe_if: operand-pair input and aligned-result output handshakes.
interface fp_align_pipe_if
  import fp_add_pkg::*;
#(
  parameter int MANT_W = FP_MANT_W,
  parameter int EXP_W = FP_EXP_W
);
  logic in_valid, in_ready, sign_a, sign_b;
  logic [EXP_W-1:0] exp_a, exp_b;
  logic [MANT_W-1:0] mant_a, mant_b;
  logic out_valid, out_ready, big_sign, small_sign, sticky, swapped;
  logic [EXP_W-1:0] big_exp;
  logic [MANT_W+GRS_W-1:0] big_mant, small_mant;
  modport slave (
    input in_valid, sign_a, sign_b, exp_a, exp_b, mant_a, mant_b, out_ready,
    output in_ready, out_valid, big_sign, small_sign, big_exp, big_mant, small_mant, sticky, swapped
  );
  modport master (
    output in_valid, sign_a, sign_b, exp_a, exp_b, mant_a, mant_b, out_ready,
    input in_ready, out_valid, big_sign, small_sign, big_exp, big_mant, small_mant, sticky, swapped
  );
endinterface

// File: rtl/fp_align_shift.sv
// fp_align_shift: saturating right shift of {mant, G, R} by diff; sticky only with FP_ALIGN_STICKY_EN.
module fp_align_shift
  import fp_add_pkg::*;
#(
  parameter int W = FP_MANT_W,
  parameter int DW = FP_EXP_W
) (
  input logic [W-1:0] mant_i,
  input logic [DW-1:0] diff_i,
  output logic [W+GRS_W-1:0] mant_o,
  output logic sticky_o
);
  logic sat;
  logic [W+GRS_W-1:0] ext;
  assign ext = {mant_i, {GRS_W{1'b0}}};
  assign sat = 32'(diff_i) >= W + GRS_W;
`ifdef FP_ALIGN_STICKY_EN
  // Double-width shift keeps the bits pushed past R for the sticky OR.
  logic [2*(W+GRS_W)-1:0] full;
  assign full = {ext, {(W+GRS_W){1'b0}}} >> diff_i;
  assign mant_o = sat ? '0 : full[2*(W+GRS_W)-1:W+GRS_W];
  assign sticky_o = sat ? |mant_i : |full[W+GRS_W-1:0];
`else
  assign mant_o = sat ? '0 : ext >> diff_i;
  assign sticky_o = 1'b0;
`endif
endmodule

// File: rtl/fp_align_pipe.sv
// fp_align_pipe: two-stage swap/align of FP operands (S1 compare+diff, S2 shift); FP_ALIGN_STICKY_EN enables sticky.
module fp_align_pipe
  import fp_add_pkg::*;
#(
  parameter int MANT_W = FP_MANT_W,
  parameter int EXP_W = FP_EXP_W
) (
  input logic clk,
  input logic rst_n,
  fp_align_pipe_if.slave bus
);
  localparam int XW = MANT_W + GRS_W;
  logic ld1, ld2, a_big;
  logic v1_q, v1_d, v2_q, v2_d;
  logic bs1_q, bs1_d, ss1_q, ss1_d, sw1_q, sw1_d;
  logic [EXP_W-1:0] be1_q, be1_d, df1_q, df1_d;
  logic [MANT_W-1:0] bm1_q, bm1_d, sm1_q, sm1_d;
  logic bs2_q, bs2_d, ss2_q, ss2_d, sw2_q, sw2_d, st2_q, st2_d, sh_st;
  logic [EXP_W-1:0] be2_q, be2_d;
  logic [XW-1:0] bm2_q, bm2_d, sm2_q, sm2_d, sh_m;

  fp_align_shift #(.W(MANT_W), .DW(EXP_W)) u_shift (
    .mant_i(sm1_q), .diff_i(df1_q), .mant_o(sh_m), .sticky_o(sh_st)
  );

  always_comb begin
    a_big = (bus.exp_a > bus.exp_b) || (bus.exp_a == bus.exp_b && bus.mant_a >= bus.mant_b);
    ld2 = v1_q && (!v2_q || bus.out_ready);
    bus.in_ready = !v1_q || ld2;
    ld1 = bus.in_valid && bus.in_ready;
    v1_d = ld1 || (v1_q && !ld2);
    v2_d = ld2 || (v2_q && !bus.out_ready);
    bs1_d = ld1 ? (a_big ? bus.sign_a : bus.sign_b) : bs1_q;
    ss1_d = ld1 ? (a_big ? bus.sign_b : bus.sign_a) : ss1_q;
    sw1_d = ld1 ? !a_big : sw1_q;
    be1_d = ld1 ? (a_big ? bus.exp_a : bus.exp_b) : be1_q;
    df1_d = ld1 ? (a_big ? bus.exp_a - bus.exp_b : bus.exp_b - bus.exp_a) : df1_q;
    bm1_d = ld1 ? (a_big ? bus.mant_a : bus.mant_b) : bm1_q;
    sm1_d = ld1 ? (a_big ? bus.mant_b : bus.mant_a) : sm1_q;
    bs2_d = ld2 ? bs1_q : bs2_q;
    ss2_d = ld2 ? ss1_q : ss2_q;
    sw2_d = ld2 ? sw1_q : sw2_q;
    be2_d = ld2 ? be1_q : be2_q;
    bm2_d = ld2 ? {bm1_q, {GRS_W{1'b0}}} : bm2_q;
    sm2_d = ld2 ? sh_m : sm2_q;
    st2_d = ld2 ? sh_st : st2_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      bs1_q <= 1'b0;
      ss1_q <= 1'b0;
      sw1_q <= 1'b0;
      be1_q <= '0;
      df1_q <= '0;
      bm1_q <= '0;
      sm1_q <= '0;
      bs2_q <= 1'b0;
      ss2_q <= 1'b0;
      sw2_q <= 1'b0;
      be2_q <= '0;
      bm2_q <= '0;
      sm2_q <= '0;
      st2_q <= 1'b0;
    end else begin
      v1_q <= v1_d;
      v2_q <= v2_d;
      bs1_q <= bs1_d;
      ss1_q <= ss1_d;
      sw1_q <= sw1_d;
      be1_q <= be1_d;
      df1_q <= df1_d;
      bm1_q <= bm1_d;
      sm1_q <= sm1_d;
      bs2_q <= bs2_d;
      ss2_q <= ss2_d;
      sw2_q <= sw2_d;
      be2_q <= be2_d;
      bm2_q <= bm2_d;
      sm2_q <= sm2_d;
      st2_q <= st2_d;
    end
  end

  assign bus.out_valid = v2_q;
  assign bus.big_sign = bs2_q;
  assign bus.small_sign = ss2_q;
  assign bus.big_exp = be2_q;
  assign bus.big_mant = bm2_q;
  assign bus.small_mant = sm2_q;
  assign bus.sticky = st2_q;
  assign bus.swapped = sw2_q;
endmodule

// File: tb/tb_fp_align_pipe.sv
// tb_fp_align_pipe: directed vector table plus streaming-stall and mid-flight reset sequences.
module tb_fp_align_pipe;
`ifdef FP_ALIGN_STICKY_EN
  localparam bit STK = 1'b1;
`else
  localparam bit STK = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fp_align_pipe_if #(.MANT_W(4), .EXP_W(4)) bus ();
  fp_align_pipe #(.MANT_W(4), .EXP_W(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {
    logic sa, sb;
    logic [3:0] ea, eb, ma, mb;
    logic bs, ss;
    logic [3:0] be;
    logic [5:0] bm, sm;
    logic st, sw;
  } vec_t;
  vec_t tv[10];
  int tests = 0;
  int fails = 0;

  function automatic logic [19:0] want(vec_t v);
    return {v.bs, v.ss, v.be, v.bm, v.sm, v.st & STK, v.sw};
  endfunction

  function automatic logic [19:0] got();
    return {bus.big_sign, bus.small_sign, bus.big_exp, bus.big_mant, bus.small_mant, bus.sticky, bus.swapped};
  endfunction

  task automatic chk(string nm, logic [31:0] g, logic [31:0] w);
    tests++;
    if (g !== w) begin
      fails++;
      $display("FAIL %s got=%h want=%h", nm, g, w);
    end
  endtask

  task automatic drive(vec_t v, logic vld);
    bus.in_valid = vld;
    bus.sign_a = v.sa;
    bus.sign_b = v.sb;
    bus.exp_a = v.ea;
    bus.exp_b = v.eb;
    bus.mant_a = v.ma;
    bus.mant_b = v.mb;
  endtask

  initial begin
    int tx, rx;
    logic acc, dr, prev_stall, saw_low;
    logic [19:0] snap;
    // sa sb ea eb ma mb | bs ss be bm sm sticky(enabled) swapped
    tv[0] = '{1'b0, 1'b1, 4'd5, 4'd3, 4'b1010, 4'b1100, 1'b0, 1'b1, 4'd5, 6'b101000, 6'b001100, 1'b0, 1'b0};
    tv[1] = '{1'b1, 1'b0, 4'd2, 4'd5, 4'b1011, 4'b1001, 1'b0, 1'b1, 4'd5, 6'b100100, 6'b000101, 1'b1, 1'b1};
    tv[2] = '{1'b0, 1'b0, 4'd4, 4'd4, 4'b0110, 4'b1001, 1'b0, 1'b0, 4'd4, 6'b100100, 6'b011000, 1'b0, 1'b1};
    tv[3] = '{1'b1, 1'b0, 4'd4, 4'd4, 4'b0111, 4'b0111, 1'b1, 1'b0, 4'd4, 6'b011100, 6'b011100, 1'b0, 1'b0};
    tv[4] = '{1'b0, 1'b1, 4'd15, 4'd0, 4'b1000, 4'b0001, 1'b0, 1'b1, 4'd15, 6'b100000, 6'b000000, 1'b1, 1'b0};
    tv[5] = '{1'b0, 1'b0, 4'd1, 4'd6, 4'b1111, 4'b1000, 1'b0, 1'b0, 4'd6, 6'b100000, 6'b000001, 1'b1, 1'b1};
    tv[6] = '{1'b1, 1'b1, 4'd7, 4'd1, 4'b1100, 4'b0011, 1'b1, 1'b1, 4'd7, 6'b110000, 6'b000000, 1'b1, 1'b0};
    tv[7] = '{1'b0, 1'b1, 4'd3, 4'd1, 4'b1001, 4'b0000, 1'b0, 1'b1, 4'd3, 6'b100100, 6'b000000, 1'b0, 1'b0};
    tv[8] = '{1'b1, 1'b0, 4'd9, 4'd10, 4'b1101, 4'b1011, 1'b0, 1'b1, 4'd10, 6'b101100, 6'b011010, 1'b0, 1'b1};
    tv[9] = '{1'b0, 1'b1, 4'd8, 4'd12, 4'b1000, 4'b1111, 1'b1, 1'b0, 4'd12, 6'b111100, 6'b000010, 1'b0, 1'b1};
    drive(tv[0], 1'b0);
    bus.out_ready = 1'b1;
    #12;
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_in_ready", 32'(bus.in_ready), 1);
    chk("rst_outputs", 32'(got()), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 10; i++) begin
      drive(tv[i], 1'b1);
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
      chk($sformatf("lat_early%0d", i), 32'(bus.out_valid), 0);
      @(posedge clk);
      #1;
      chk($sformatf("lat_valid%0d", i), 32'(bus.out_valid), 1);
      chk($sformatf("vec%0d", i), 32'(got()), 32'(want(tv[i])));
      @(posedge clk);
      #1;
    end
    // Back-to-back stream with a stall window on cycles 3..6
    tx = 0;
    rx = 0;
    prev_stall = 1'b0;
    saw_low = 1'b0;
    snap = '0;
    for (int c = 0; c < 60 && rx < 8; c++) begin
      bus.out_ready = !(c >= 3 && c <= 6);
      if (tx < 8) drive(tv[tx], 1'b1);
      else bus.in_valid = 1'b0;
      #1;
      if (prev_stall) begin
        chk("stall_valid", 32'(bus.out_valid), 1);
        chk("stall_hold", 32'(got()), 32'(snap));
      end
      if (!bus.in_ready) saw_low = 1'b1;
      acc = bus.in_valid && bus.in_ready;
      dr = bus.out_valid && bus.out_ready;
      if (dr) chk($sformatf("stream%0d", rx), 32'(got()), 32'(want(tv[rx])));
      prev_stall = bus.out_valid && !bus.out_ready;
      snap = got();
      @(posedge clk);
      #1;
      tx += int'(acc);
      rx += int'(dr);
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    chk("stream_count", 32'(rx), 8);
    chk("in_ready_dropped", 32'(saw_low), 1);
    repeat (3) @(posedge clk);
    #1;
    chk("no_duplicate", 32'(bus.out_valid), 0);
    // Reset with two results in flight
    bus.out_ready = 1'b0;
    drive(tv[1], 1'b1);
    @(posedge clk);
    #1 drive(tv[2], 1'b1);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    chk("inflight_valid", 32'(bus.out_valid), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_valid", 32'(bus.out_valid), 0);
    chk("rst_async_ready", 32'(bus.in_ready), 1);
    chk("rst_async_outputs", 32'(got()), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("no_partial", 32'(bus.out_valid), 0);
    chk("post_rst_ready", 32'(bus.in_ready), 1);
    drive(tv[4], 1'b1);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_valid", 32'(bus.out_valid), 1);
    chk("post_rst_vec", 32'(got()), 32'(want(tv[4])));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/fp_align_pipe.md
Name: fp_align_pipe

Overview:
- Parametrised, pipelined successor to the adder's big/small mantissa selector.
- Takes two unpacked FP operands and selects the larger one, first by exponent, then by mantissa on an exponent tie.
- Right-aligns the smaller mantissa by the exponent difference, producing guard, round and sticky bits.
- Sits between operand unpack and the mantissa add/sub stage of the FP adder; valid/ready on both sides.

Parameters:
- MANT_W, 4, mantissa width including hidden bit
- EXP_W, 4, exponent width (unsigned, biased)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand pair valid
- in_ready  out  1  block accepts operand pair this cycle
- sign_a, sign_b  in  1 each  operand signs
- exp_a, exp_b  in  EXP_W each  operand exponents
- mant_a, mant_b  in  MANT_W each  operand mantissas
- out_valid  out  1  aligned result valid
- out_ready  in  1  downstream accepts result
- big_sign  out  1  sign of larger operand
- small_sign  out  1  sign of smaller operand
- big_exp  out  EXP_W  exponent of larger operand (result exponent)
- big_mant  out  MANT_W+2  larger mantissa with two zero LSBs appended
- small_mant  out  MANT_W+2  aligned smaller mantissa: {mant, G, R} shifted right
- sticky  out  1  OR of all bits shifted past R
- swapped  out  1  1 when operand b was selected as big

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous, active-low, on rst_n.
- Reset values: all valid flags and all output registers are 0; in_ready is 1 out of reset (pipeline empty).
- Pipeline: two register stages. S1 does compare/swap and computes diff = |exp_a - exp_b|. S2 does the shift and sticky.
- Latency: accepted at edge N, result presented at edge N+2 with no stall. Throughput is 1 per cycle.
- Select rule:
  - exp_a > exp_b, or exps equal and mant_a >= mant_b: big = a, swapped = 0.
  - Otherwise: big = b, swapped = 1.
  - A full tie (equal exp and equal mant) selects a.
- Shift: small_ext = {small_mant_in, 2'b00}; small_mant = small_ext >> diff.
  - sticky = OR of the bits of small_ext shifted below bit 0.
- Saturation: if diff >= MANT_W+2, small_mant = 0 and sticky = |small_mant_in. The shifter must not wrap for large diff.
- Handshake:
  - Stage k loads when its upstream valid is high and (stage k empty or stage k advancing).
  - out_valid is S2 valid. S2 advances when out_ready is 1.
  - in_ready = !S1_valid | S1 advancing. in_ready is combinational from out_ready through the chain; no skid buffer.
- Stall: while out_valid=1 and out_ready=0, all outputs hold stable and no stage data changes.
- Simultaneous events: a full pipeline with out_ready=1 and in_valid=1 accepts a new pair and drains one result in the same cycle.
- Reset mid-operation: in-flight data is discarded and valids clear immediately (asynchronous); no partial result emerges.
- Zero mantissas: mant = 0 is handled normally; sticky = 0.

Optional Feature:
- Macro: FP_ALIGN_STICKY_EN.
- Defined: sticky is computed as above.
- Undefined: sticky output is tied to 0, the sticky OR-reduction logic is removed, and the saturated case yields small_mant = 0, sticky = 0.
- All other behaviour is identical.

Decomposition:
- Package fp_add_pkg holds:
  - default constants FP_MANT_W = 4 and FP_EXP_W = 4, plus the GRS width constant 2;
  - typedef struct fp_operand_t {sign, exp, mant};
  - typedef struct fp_aligned_t carrying the output bundle.
- One sub-module: fp_align_shift.
  - Combinational parametrised right shifter with saturation and sticky generation.
  - Instantiated in S2; unit-testable alone.

Test Plan:
- MANT_W=4, EXP_W=4, exp_a=5, mant_a=1010, exp_b=3, mant_b=1100 -> 2 cycles later: big_mant=101000, small_mant=001100, sticky=0, big_exp=5, swapped=0.
- exp_a=2, mant_a=1011, exp_b=5, mant_b=1001 -> swapped=1, big_exp=5, big_mant=100100, small_mant=000101, sticky=1.
- Equal exps 4, mant_a=0110, mant_b=1001 -> swapped=1, small_mant=011000, sticky=0. Full tie (exp 4, mant 0111 both) -> swapped=0.
- exp_a=15, exp_b=0, mant_b=0001 -> small_mant=000000, sticky=1 (0 when FP_ALIGN_STICKY_EN undefined).
- Back-to-back 8 pairs with out_ready held 0 for cycles 3-6:
  - in_ready drops once both stages are full;
  - outputs stay stable during the stall;
  - all 8 results emerge in order, none lost or duplicated.
- Assert rst_n low while 2 results are in flight -> out_valid=0 immediately and in_ready=1 after release; the next accepted pair produces the correct result.
